// File: rtl/opb_master_cmd_bridge.sv
// OPB bus master: turns single user read/write commands into OPB request/grant,
// select and acknowledge phases, with bounded retries and a select timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// REQ     | M_request high, waiting for OPB_MGrant
// XFER    | M_select high, bus driven, waiting for ack/err/retry/timeout
// BACKOFF | one dead cycle after a retry before requesting again
// RESP    | rsp_valid pulse with captured data and status
module opb_master_cmd_bridge #(
    parameter int C_OPB_AWIDTH     = 32,
    parameter int C_OPB_DWIDTH     = 32,
    parameter int C_TIMEOUT_CYCLES = 16,
    parameter int C_MAX_RETRIES    = 7
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [C_OPB_AWIDTH-1:0]     cmd_addr,
    input  logic [C_OPB_DWIDTH-1:0]     cmd_wdata,
    input  logic [C_OPB_DWIDTH/8-1:0]   cmd_be,
    output logic                        rsp_valid,
    output logic [C_OPB_DWIDTH-1:0]     rsp_rdata,
    output logic [1:0]                  rsp_status,
    output logic                        M_request,
    input  logic                        OPB_MGrant,
    output logic                        M_select,
    output logic                        M_RNW,
    output logic [0:C_OPB_AWIDTH-1]     M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
    output logic [0:C_OPB_DWIDTH-1]     M_DBus,
    output logic                        M_seqAddr,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_xferAck,
    input  logic                        OPB_errAck,
    input  logic                        OPB_retry,
    input  logic                        OPB_toutSup
);

    localparam int BEW = C_OPB_DWIDTH / 8;
    localparam int RW  = $clog2(C_MAX_RETRIES + 2);
    localparam int TW  = $clog2(C_TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_ERR  = 2'b01;
    localparam logic [1:0] ST_TOUT = 2'b10;
    localparam logic [1:0] ST_RTRY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_BACKOFF,
        S_RESP
    } state_t;

    state_t                  state, state_n;
    logic                    rnw_q, rnw_n;
    logic [C_OPB_AWIDTH-1:0] addr_q, addr_n;
    logic [C_OPB_DWIDTH-1:0] wdata_q, wdata_n;
    logic [BEW-1:0]          be_q, be_n;
    logic [RW-1:0]           retry_cnt, retry_cnt_n;
    logic [TW-1:0]           tout_cnt, tout_cnt_n;
    logic [1:0]              status_q, status_n;
    logic [C_OPB_DWIDTH-1:0] rdata_q, rdata_n;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state     <= S_IDLE;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            retry_cnt <= '0;
            tout_cnt  <= '0;
            status_q  <= ST_OK;
            rdata_q   <= '0;
        end else begin
            state     <= state_n;
            rnw_q     <= rnw_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            be_q      <= be_n;
            retry_cnt <= retry_cnt_n;
            tout_cnt  <= tout_cnt_n;
            status_q  <= status_n;
            rdata_q   <= rdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        rnw_n       = rnw_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        be_n        = be_q;
        retry_cnt_n = retry_cnt;
        tout_cnt_n  = tout_cnt;
        status_n    = status_q;
        rdata_n     = rdata_q;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    rnw_n       = cmd_rnw;
                    addr_n      = cmd_addr;
                    wdata_n     = cmd_wdata;
                    be_n        = cmd_be;
                    retry_cnt_n = '0;
                    state_n     = S_REQ;
                end
            end
            S_REQ: begin
                if (OPB_MGrant) begin
                    tout_cnt_n = '0;
                    state_n    = S_XFER;
                end
            end
            S_XFER: begin
                if (OPB_errAck) begin
                    status_n = ST_ERR;
                    rdata_n  = '0;
                    state_n  = S_RESP;
                end else if (OPB_xferAck) begin
                    status_n = ST_OK;
                    rdata_n  = rnw_q ? OPB_DBus : '0;
                    state_n  = S_RESP;
                end else if (OPB_retry) begin
                    retry_cnt_n = retry_cnt + RW'(1);
                    // Current count already at the limit: this retry pushes it past.
                    if (retry_cnt >= RW'(C_MAX_RETRIES)) begin
                        status_n = ST_RTRY;
                        rdata_n  = '0;
                        state_n  = S_RESP;
                    end else begin
                        state_n = S_BACKOFF;
                    end
                end else if (!OPB_toutSup) begin
                    if (tout_cnt == TW'(C_TIMEOUT_CYCLES - 1)) begin
                        status_n = ST_TOUT;
                        rdata_n  = '0;
                        state_n  = S_RESP;
                    end else begin
                        tout_cnt_n = tout_cnt + TW'(1);
                    end
                end
            end
            S_BACKOFF: state_n = S_REQ;
            S_RESP:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Bus outputs are zero when not selected so they can be OR-ed onto the OPB.
    assign cmd_ready  = (state == S_IDLE);
    assign M_request  = (state == S_REQ) || (state == S_XFER);
    assign M_select   = (state == S_XFER);
    assign M_RNW      = M_select & rnw_q;
    assign M_ABus     = M_select ? addr_q : '0;
    assign M_BE       = M_select ? be_q : '0;
    assign M_DBus     = (M_select && !rnw_q) ? wdata_q : '0;
    assign M_seqAddr  = 1'b0;
    assign rsp_valid  = (state == S_RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;

endmodule

// File: tb/tb_opb_master_cmd_bridge.sv
// Bench for opb_master_cmd_bridge: a scripted OPB slave/arbiter plus a
// transaction-level outcome model computed from the per-select-cycle script.
module tb_opb_master_cmd_bridge;

    localparam int MAXS = 256;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        M_request;
    logic        OPB_MGrant = 1'b0;
    logic        M_select;
    logic        M_RNW;
    logic [0:31] M_ABus;
    logic [0:3]  M_BE;
    logic [0:31] M_DBus;
    logic        M_seqAddr;
    logic [0:31] OPB_DBus = '0;
    logic        OPB_xferAck = 1'b0;
    logic        OPB_errAck = 1'b0;
    logic        OPB_retry = 1'b0;
    logic        OPB_toutSup = 1'b0;

    opb_master_cmd_bridge dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .M_request(M_request), .OPB_MGrant(OPB_MGrant), .M_select(M_select),
        .M_RNW(M_RNW), .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
        .M_seqAddr(M_seqAddr), .OPB_DBus(OPB_DBus), .OPB_xferAck(OPB_xferAck),
        .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave script, one entry per select cycle.
    // code: 0 none, 1 ack, 2 retry, 3 err, 4 err+ack, 5 retry+ack, 6 retry+err
    logic [2:0]  scr  [0:MAXS-1];
    logic        sup  [0:MAXS-1];
    logic [31:0] dbus [0:MAXS-1];
    logic [31:0] last_rdata = '0;

    function automatic bit is_ack(input logic [2:0] c);
        return (c == 3'd1) || (c == 3'd4) || (c == 3'd5);
    endfunction
    function automatic bit is_err(input logic [2:0] c);
        return (c == 3'd3) || (c == 3'd4) || (c == 3'd6);
    endfunction
    function automatic bit is_rty(input logic [2:0] c);
        return (c == 3'd2) || (c == 3'd5) || (c == 3'd6);
    endfunction

    task automatic clear_script();
        for (int i = 0; i < MAXS; i++) begin
            scr[i]  = 3'd0;
            sup[i]  = 1'b0;
            dbus[i] = $urandom;
        end
    endtask

    task automatic random_script();
        int r;
        for (int i = 0; i < MAXS; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      scr[i] = 3'd0;
            else if (r < 65) scr[i] = 3'd1;
            else if (r < 82) scr[i] = 3'd2;
            else if (r < 90) scr[i] = 3'd3;
            else if (r < 94) scr[i] = 3'd4;
            else if (r < 97) scr[i] = 3'd5;
            else             scr[i] = 3'd6;
            sup[i]  = ($urandom_range(0, 3) == 0);
            dbus[i] = $urandom;
        end
    endtask

    // Outcome of one command from the slave's point of view.
    task automatic model(input logic rnw, output logic [1:0] st, output logic [31:0] rd,
                         output int nsel, output int nb);
        int retries = 0;
        int waited  = 0;
        st = 2'b00; rd = '0; nsel = 0; nb = 0;
        for (int i = 0; i < MAXS; i++) begin
            nsel = i + 1;
            if (is_err(scr[i])) begin st = 2'b01; return; end
            if (is_ack(scr[i])) begin st = 2'b00; rd = rnw ? dbus[i] : 32'h0; return; end
            if (is_rty(scr[i])) begin
                retries++;
                if (retries > 7) begin st = 2'b11; return; end
                nb++;
                waited = 0;
            end else if (!sup[i]) begin
                waited++;
                if (waited == 16) begin st = 2'b10; return; end
            end
        end
    endtask

    task automatic drive_junk();
        OPB_xferAck = 1'($urandom);
        OPB_errAck  = 1'($urandom);
        OPB_retry   = 1'($urandom);
        OPB_toutSup = 1'($urandom);
        OPB_DBus    = $urandom;
    endtask

    task automatic do_txn(input string name, input logic rnw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int gdelay);
        logic [1:0]  exp_st;
        logic [31:0] exp_rd;
        int exp_sel, exp_nb, exp_lat;
        int sel_idx = 0, req_wait = 0, cyc = 0, nb_obs = 0, bus_bad = 0;
        bit done = 0;
        model(rnw, exp_st, exp_rd, exp_sel, exp_nb);
        exp_lat = (exp_nb + 1) * (gdelay + 1) + exp_sel + exp_nb + 1;

        @(negedge OPB_Clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_at_start: got %b want 1", name, cmd_ready);
        end
        n_tests++;
        if (rsp_rdata !== last_rdata) begin
            n_fail++;
            $display("FAIL %s rdata_held: got %h want %h", name, rsp_rdata, last_rdata);
        end
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
        drive_junk();
        OPB_MGrant = 1'($urandom);
        @(posedge OPB_Clk);

        while (!done && cyc < 3000) begin
            @(negedge OPB_Clk);
            cyc++;
            cmd_valid = 1'b0; cmd_rnw = 1'($urandom); cmd_addr = $urandom;
            cmd_wdata = $urandom; cmd_be = 4'($urandom);
            if (M_select) begin
                if (M_ABus !== addr || M_BE !== be || M_RNW !== rnw || !M_request ||
                    M_DBus !== (rnw ? 32'h0 : wdata)) bus_bad++;
            end else if (M_ABus !== 32'h0 || M_BE !== 4'h0 || M_RNW !== 1'b0 || M_DBus !== 32'h0) begin
                bus_bad++;
            end
            if (M_seqAddr !== 1'b0 || cmd_ready !== 1'b0) bus_bad++;
            if (rsp_valid) begin
                done = 1;
                if (M_request || M_select) bus_bad++;
                drive_junk();
                OPB_MGrant = 1'($urandom);
            end else if (M_select) begin
                OPB_xferAck = is_ack(scr[sel_idx]);
                OPB_errAck  = is_err(scr[sel_idx]);
                OPB_retry   = is_rty(scr[sel_idx]);
                OPB_toutSup = sup[sel_idx];
                OPB_DBus    = dbus[sel_idx];
                OPB_MGrant  = 1'($urandom);
                if (sel_idx < MAXS - 1) sel_idx++;
                req_wait = 0;
            end else if (M_request) begin
                drive_junk();
                OPB_MGrant = (req_wait >= gdelay);
                req_wait++;
            end else begin
                nb_obs++;
                drive_junk();
                OPB_MGrant = 1'($urandom);
            end
        end

        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s no_response: waited %0d cycles", name, cyc);
            return;
        end
        if (rsp_status !== exp_st) begin
            n_fail++;
            $display("FAIL %s status: got %b want %b", name, rsp_status, exp_st);
        end
        n_tests++;
        if (rsp_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, exp_rd);
        end
        n_tests++;
        if (sel_idx !== exp_sel || nb_obs !== exp_nb) begin
            n_fail++;
            $display("FAIL %s select_backoff: got sel %0d bo %0d want sel %0d bo %0d",
                     name, sel_idx, nb_obs, exp_sel, exp_nb);
        end
        n_tests++;
        if (cyc !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        n_tests++;
        if (bus_bad !== 0) begin
            n_fail++;
            $display("FAIL %s bus_rule: got %0d bad cycles want 0", name, bus_bad);
        end
        last_rdata = exp_rd;
    endtask

    task automatic test_reset();
        OPB_Rst = 1'b1;
        repeat (3) @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        n_tests++;
        if ({M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, rsp_valid, rsp_rdata, rsp_status} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req %b sel %b rsp %b rdata %h st %b want all 0",
                     M_request, M_select, rsp_valid, rsp_rdata, rsp_status);
        end
        OPB_Rst = 1'b0;
        @(negedge OPB_Clk);
        n_tests++;
        if (cmd_ready !== 1'b1 || M_request !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready %b req %b rsp %b want 1 0 0", cmd_ready, M_request, rsp_valid);
        end
        last_rdata = '0;
    endtask

    task automatic test_min_write();
        clear_script();
        scr[0] = 3'd1;
        do_txn("min_write", 1'b0, 32'h0108_3000, 32'hDEAD_BEEF, 4'hF, 0);
    endtask

    task automatic test_delayed_read();
        clear_script();
        scr[1]  = 3'd1;
        dbus[1] = 32'h1234_5678;
        do_txn("delayed_read", 1'b1, 32'h0000_0A04, 32'h5555_AAAA, 4'h3, 3);
    endtask

    task automatic test_retry_exhaust();
        clear_script();
        for (int i = 0; i < MAXS; i++) scr[i] = 3'd2;
        do_txn("retry_exhaust", 1'b1, 32'h0000_1000, 32'h0, 4'hF, 1);
    endtask

    task automatic test_timeout();
        clear_script();
        do_txn("timeout", 1'b1, 32'h0000_2000, 32'h0, 4'hF, 0);
        clear_script();
        for (int i = 0; i < 20; i++) sup[i] = 1'b1;
        scr[20] = 3'd1;
        do_txn("tout_suppress", 1'b0, 32'h0000_2004, 32'hCAFE_F00D, 4'h8, 2);
    endtask

    task automatic test_err_priority();
        clear_script();
        scr[0] = 3'd4;
        do_txn("err_priority", 1'b1, 32'h0000_3000, 32'h0, 4'hF, 0);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(negedge OPB_Clk);
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h0000_4000; cmd_be = 4'hF;
        OPB_MGrant = 1'b0;
        @(negedge OPB_Clk);
        cmd_valid = 1'b0;
        n_tests++;
        if (M_request !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_req: got %b want 1", M_request);
        end
        OPB_Rst = 1'b1;
        OPB_MGrant = 1'b1;
        @(negedge OPB_Clk);
        n_tests++;
        if ({M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, rsp_valid, rsp_rdata, rsp_status} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got req %b sel %b rsp %b rdata %h want all 0",
                     M_request, M_select, rsp_valid, rsp_rdata);
        end
        OPB_Rst = 1'b0;
        OPB_MGrant = 1'b0;
        last_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge OPB_Clk);
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || M_request !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_release: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            random_script();
            do_txn("random", 1'($urandom), $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 3; t++) begin
            clear_script();
            scr[0] = 3'd1;
            do_txn("back_to_back", 1'(t % 2), 32'h100 + 32'(t * 4), $urandom, 4'hF, 0);
        end
    endtask

    initial begin
        clear_script();
        test_reset();
        test_min_write();
        test_delayed_read();
        test_retry_exhaust();
        test_timeout();
        test_err_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
